// File: rtl/gray_code_counter_if.sv
// Bundles the count-control inputs and the registered code/count outputs
// of gray_code_counter.
//   master : drives en, up_dn, wrap_en, load, load_bin; observes outputs
//   slave  : the counter itself; receives controls, drives outputs
interface gray_code_counter_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic             up_dn;
  logic             wrap_en;
  logic             load;
  logic [WIDTH-1:0] load_bin;
  logic [WIDTH-1:0] gray_out;
  logic [WIDTH-1:0] bin_out;
  logic             tc;
  logic             at_end;

  modport master (
    output en, up_dn, wrap_en, load, load_bin,
    input  gray_out, bin_out, tc, at_end
  );

  modport slave (
    input  en, up_dn, wrap_en, load, load_bin,
    output gray_out, bin_out, tc, at_end
  );
endinterface

// File: rtl/gray_code_counter.sv
// Up/down counter that emits a Gray-coded count alongside its binary count.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, clears every output
//   bus  : gray_code_counter_if.slave
//          en/up_dn/wrap_en/load/load_bin in; gray_out/bin_out/tc/at_end out
// All outputs are registered; priority is rst > load > en > hold.
module gray_code_counter #(
  parameter int WIDTH = 4
) (
  input logic                clk,
  input logic                rst,
  gray_code_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  function automatic logic [WIDTH-1:0] to_gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  logic [WIDTH-1:0] bin_p1;
  logic [WIDTH-1:0] gray_p1;
  logic             tc_p1;
  logic             at_end_p1;

  logic [WIDTH-1:0] bin_nxt;
  logic [WIDTH-1:0] end_val;
  logic             tc_nxt;
  logic             at_end_nxt;

  always_comb begin
    bin_nxt    = bin_p1;
    tc_nxt     = 1'b0;
    end_val    = bus.up_dn ? ALL_ONES : '0;
    if (bus.load) begin
      bin_nxt = bus.load_bin;
    end else if (bus.en) begin
      if (bin_p1 == end_val) begin
        // At the end of the range: wrap with a tc pulse, or saturate silently.
        if (bus.wrap_en) begin
          bin_nxt = bus.up_dn ? '0 : ALL_ONES;
          tc_nxt  = 1'b1;
        end
      end else begin
        bin_nxt = bus.up_dn ? bin_p1 + ONE : bin_p1 - ONE;
      end
    end
    // at_end looks at the post-update count with the direction sampled now.
    at_end_nxt = (bin_nxt == end_val);
  end

  // Stage p1: registered count, code and flags
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_p1    <= '0;
      gray_p1   <= '0;
      tc_p1     <= 1'b0;
      at_end_p1 <= 1'b0;
    end else begin
      bin_p1    <= bin_nxt;
      gray_p1   <= to_gray(bin_nxt);
      tc_p1     <= tc_nxt;
      at_end_p1 <= at_end_nxt;
    end
  end

  assign bus.bin_out  = bin_p1;
  assign bus.gray_out = gray_p1;
  assign bus.tc       = tc_p1;
  assign bus.at_end   = at_end_p1;

endmodule

// File: tb/tb_gray_code_counter.sv
// Bench for gray_code_counter: directed scenarios plus randomized traffic,
// checked every cycle against a behavioural integer model, with a
// Gray-to-binary decoder on gray_out.
module tb_gray_code_counter;

  localparam int W   = 4;
  localparam int MOD = 1 << W;
  localparam int MAX = MOD - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  gray_code_counter_if #(.WIDTH(W)) bus ();

  gray_code_counter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int m_bin   = 0;
  int m_tc    = 0;
  int m_end   = 0;
  bit m_valid = 1'b0;
  bit m_step  = 1'b0;
  logic [W-1:0] prev_gray = '0;

  function automatic int gray_of(input int b);
    return (b ^ (b >> 1)) & MAX;
  endfunction

  // Gray-to-binary converter fed by the DUT's gray_out
  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    logic [W-1:0] b;
    b[W-1] = g[W-1];
    for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_bin = 0; m_tc = 0; m_end = 0; m_step = 1'b0; m_valid = 1'b1;
    end else begin
      m_tc   = 0;
      m_step = 1'b0;
      if (bus.load) begin
        m_bin = int'(bus.load_bin);
      end else if (bus.en) begin
        if (bus.up_dn && m_bin == MAX) begin
          if (bus.wrap_en) begin m_bin = 0; m_tc = 1; m_step = 1'b1; end
        end else if (!bus.up_dn && m_bin == 0) begin
          if (bus.wrap_en) begin m_bin = MAX; m_tc = 1; m_step = 1'b1; end
        end else begin
          m_bin  = (m_bin + (bus.up_dn ? 1 : MOD - 1)) % MOD;
          m_step = 1'b1;
        end
      end
      m_end = bus.up_dn ? int'(m_bin == MAX) : int'(m_bin == 0);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      chk("bin_out", int'(bus.bin_out), m_bin);
      chk("gray_out", int'(bus.gray_out), gray_of(m_bin));
      chk("tc", int'(bus.tc), m_tc);
      chk("at_end", int'(bus.at_end), m_end);
      chk("g2b_vs_bin", int'(g2b(bus.gray_out)), m_bin);
      if (m_step) chk("one_bit_change", $countones(bus.gray_out ^ prev_gray), 1);
      prev_gray = bus.gray_out;
    end
  end

  // ---------------- stimulus ----------------
  // Called at a negedge; applies inputs and returns at the next negedge,
  // when the outputs reflect this cycle's decision.
  task automatic cyc(input bit r, input bit e, input bit u, input bit w,
                     input bit l, input int lb);
    rst          = r;
    bus.en       = e;
    bus.up_dn    = u;
    bus.wrap_en  = w;
    bus.load     = l;
    bus.load_bin = W'(lb);
    @(negedge clk);
  endtask

  int gray_tab [16] = '{0, 1, 3, 2, 6, 7, 5, 4, 12, 13, 15, 14, 10, 11, 9, 8};

  initial begin
    bus.en = 1'b0; bus.up_dn = 1'b1; bus.wrap_en = 1'b1;
    bus.load = 1'b0; bus.load_bin = '0;
    @(negedge clk);

    // Reset state
    cyc(1, 0, 1, 1, 0, 0);
    cyc(1, 1, 1, 1, 1, 7);
    chk("lit_reset_bin", int'(bus.bin_out), 0);
    chk("lit_reset_gray", int'(bus.gray_out), 0);
    chk("lit_reset_tc", int'(bus.tc), 0);
    chk("lit_reset_at_end", int'(bus.at_end), 0);

    // Full up-count with wrap
    for (int i = 1; i <= 16; i++) begin
      cyc(0, 1, 1, 1, 0, 0);
      chk("lit_seq_gray", int'(bus.gray_out), gray_tab[i % 16]);
      chk("lit_seq_tc", int'(bus.tc), (i == 16) ? 1 : 0);
    end

    // Load overrides en
    cyc(0, 1, 1, 1, 1, 5);
    chk("lit_load_bin", int'(bus.bin_out), 5);
    chk("lit_load_gray", int'(bus.gray_out), 4'b0111);
    chk("lit_load_tc", int'(bus.tc), 0);
    cyc(0, 1, 1, 1, 0, 0);
    chk("lit_load_step_bin", int'(bus.bin_out), 6);
    chk("lit_load_step_gray", int'(bus.gray_out), 4'b0101);

    // Down wrap from 0
    cyc(0, 0, 0, 1, 1, 0);
    cyc(0, 1, 0, 1, 0, 0);
    chk("lit_dwrap_bin", int'(bus.bin_out), 15);
    chk("lit_dwrap_gray", int'(bus.gray_out), 4'b1000);
    chk("lit_dwrap_tc", int'(bus.tc), 1);
    cyc(0, 0, 0, 1, 0, 0);
    chk("lit_dwrap_tc_off", int'(bus.tc), 0);

    // Down saturate at 0
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 1, 0, 0, 0, 0);
    chk("lit_dsat_bin", int'(bus.bin_out), 0);
    chk("lit_dsat_tc", int'(bus.tc), 0);
    chk("lit_dsat_at_end", int'(bus.at_end), 1);

    // Up saturate at 15
    cyc(0, 0, 1, 0, 1, 14);
    cyc(0, 1, 1, 0, 0, 0);
    chk("lit_usat_bin1", int'(bus.bin_out), 15);
    cyc(0, 1, 1, 0, 0, 0);
    chk("lit_usat_bin2", int'(bus.bin_out), 15);
    chk("lit_usat_gray", int'(bus.gray_out), 4'b1000);
    chk("lit_usat_at_end", int'(bus.at_end), 1);
    chk("lit_usat_tc", int'(bus.tc), 0);

    // Direction change mid-stream
    cyc(0, 0, 1, 1, 1, 10);
    chk("lit_dir_gray0", int'(bus.gray_out), 4'b1111);
    cyc(0, 1, 1, 1, 0, 0);
    chk("lit_dir_bin1", int'(bus.bin_out), 11);
    chk("lit_dir_gray1", int'(bus.gray_out), 4'b1110);
    cyc(0, 1, 0, 1, 0, 0);
    chk("lit_dir_bin2", int'(bus.bin_out), 10);
    chk("lit_dir_gray2", int'(bus.gray_out), 4'b1111);

    // Reset mid-count beats load and en
    cyc(0, 0, 1, 1, 1, 8);
    cyc(0, 1, 1, 1, 0, 0);
    chk("lit_rst_pre", int'(bus.bin_out), 9);
    cyc(1, 1, 1, 1, 1, 12);
    chk("lit_rst_bin", int'(bus.bin_out), 0);
    chk("lit_rst_gray", int'(bus.gray_out), 0);
    chk("lit_rst_tc", int'(bus.tc), 0);
    cyc(0, 1, 1, 1, 0, 0);
    chk("lit_rst_resume", int'(bus.bin_out), 1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
          1'($urandom), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 7) == 0), int'($urandom_range(0, MAX)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
